// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared status codes, receiver states and frame-length helper
package cfg_pkg;

   localparam logic [1:0] ST_OK   = 2'd0;
   localparam logic [1:0] ST_LEN  = 2'd1;
   localparam logic [1:0] ST_PAR  = 2'd2;
   localparam logic [1:0] ST_ADDR = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_PAR,
      S_OVER
   } state_e;

   function automatic int flen(input int addrw, input int dataw);
      return addrw + dataw + 1;
   endfunction

endpackage

// File: rtl/cfg_frame_rx.sv
// rtl/cfg_frame_rx.sv - serial frame receiver: FSM, bit counter, field shifters, parity
module cfg_frame_rx
   import cfg_pkg::*;
#(
   parameter int ADDRW = 3,
   parameter int DATAW = 16,
   parameter int NBANK = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             sel_i,
   input  logic             sdi_i,
   output logic             busy_o,
   output logic             frame_done_o,
   output logic [ADDRW-1:0] addr_o,
   output logic [DATAW-1:0] data_o,
   output logic [1:0]       status_o,
   output logic             addr_last_o,
   output logic [ADDRW-1:0] addr_next_o,
   output logic             data_bit_o,
   output logic             data_last_o
);

   localparam int FLEN = flen(ADDRW, DATAW);
   localparam int CW   = $clog2(FLEN + 1);
   localparam logic [CW-1:0] C_ONE   = CW'(1);
   localparam logic [CW-1:0] C_ALAST = CW'(ADDRW - 1);
   localparam logic [CW-1:0] C_ADDR  = CW'(ADDRW);
   localparam logic [CW-1:0] C_DLAST = CW'(ADDRW + DATAW - 1);
   localparam logic [CW-1:0] C_DEND  = CW'(ADDRW + DATAW);
   localparam logic [CW-1:0] C_FLEN  = CW'(FLEN);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [ADDRW-1:0] addr_q, addr_d;
   logic [DATAW-1:0] data_q, data_d;
   logic             par_q, par_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         par_q   <= par_d;
      end
   end

   // State names the field the next sampled bit belongs to; the counter saturates at FLEN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      par_d   = par_q;
      if (sel_i) begin
         cnt_d = (cnt_q == C_FLEN) ? cnt_q : cnt_q + 1'b1;
         par_d = par_q ^ sdi_i;
         unique case (state_q)
            S_IDLE: begin
               cnt_d   = C_ONE;
               par_d   = sdi_i;
               addr_d  = ADDRW'(sdi_i);
               data_d  = '0;
               state_d = (C_ADDR == C_ONE) ? S_DATA : S_ADDR;
            end
            S_ADDR: begin
               addr_d  = ADDRW'({addr_q, sdi_i});
               state_d = (cnt_d == C_ADDR) ? S_DATA : S_ADDR;
            end
            S_DATA: begin
               data_d  = DATAW'({data_q, sdi_i});
               state_d = (cnt_d == C_DEND) ? S_PAR : S_DATA;
            end
            S_PAR: begin
               if (cnt_q == C_FLEN) state_d = S_OVER;
            end
            S_OVER: state_d = S_OVER;
            default: state_d = S_IDLE;
         endcase
      end else begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end
   end

   always_comb begin
      busy_o       = (state_q != S_IDLE);
      frame_done_o = (state_q != S_IDLE) && !sel_i;
      if (state_q == S_OVER || cnt_q != C_FLEN) status_o = ST_LEN;
      else if (par_q)                           status_o = ST_PAR;
      else if (int'(addr_q) >= NBANK)           status_o = ST_ADDR;
      else                                      status_o = ST_OK;
      addr_last_o  = sel_i && (state_q == S_IDLE || state_q == S_ADDR) && (cnt_q == C_ALAST);
      addr_next_o  = addr_d;
      data_bit_o   = sel_i && (state_q == S_DATA);
      data_last_o  = sel_i && (state_q == S_DATA) && (cnt_q == C_DLAST);
      addr_o       = addr_q;
      data_o       = data_q;
   end

endmodule

// File: rtl/cfg_bank_loader.sv
// rtl/cfg_bank_loader.sv - addressed configuration bank loader with serial readback
module cfg_bank_loader
   import cfg_pkg::*;
#(
   parameter int DATAW = 16,
   parameter int NBANK = 8,
   parameter int ADDRW = 3
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   SEL,
   input  logic                   SDI,
   output logic                   SDO,
   output logic [NBANK*DATAW-1:0] CNF,
   output logic [NBANK-1:0]       UPD,
   output logic [1:0]             STATUS,
   output logic                   BUSY
);

   logic             rx_busy, rx_done, rx_addr_last, rx_data_bit, rx_data_last;
   logic [ADDRW-1:0] rx_addr, rx_addr_next;
   logic [DATAW-1:0] rx_data;
   logic [1:0]       rx_status;

   logic [NBANK*DATAW-1:0] cnf_q, cnf_d;
   logic [NBANK-1:0]       upd_q, upd_d;
   logic [1:0]             status_q, status_d;
   logic [DATAW-1:0]       rb_q, rb_d, rb_new;
   logic                   sdo_q, sdo_d;

   cfg_frame_rx #(
      .ADDRW(ADDRW),
      .DATAW(DATAW),
      .NBANK(NBANK)
   ) u_rx (
      .clk_i        (CLK),
      .rst_ni       (RST_N),
      .sel_i        (SEL),
      .sdi_i        (SDI),
      .busy_o       (rx_busy),
      .frame_done_o (rx_done),
      .addr_o       (rx_addr),
      .data_o       (rx_data),
      .status_o     (rx_status),
      .addr_last_o  (rx_addr_last),
      .addr_next_o  (rx_addr_next),
      .data_bit_o   (rx_data_bit),
      .data_last_o  (rx_data_last)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnf_q    <= '0;
         upd_q    <= '0;
         status_q <= ST_OK;
         rb_q     <= '0;
         sdo_q    <= 1'b0;
      end else begin
         cnf_q    <= cnf_d;
         upd_q    <= upd_d;
         status_q <= status_d;
         rb_q     <= rb_d;
         sdo_q    <= sdo_d;
      end
   end

   // Readback snapshot is taken while the address completes, so a same-frame commit returns old data.
   always_comb begin
      rb_new = '0;
      for (int b = 0; b < NBANK; b++) begin
         if (int'(rx_addr_next) == b) rb_new = cnf_q[b*DATAW +: DATAW];
      end
      cnf_d    = cnf_q;
      upd_d    = '0;
      status_d = status_q;
      rb_d     = rb_q;
      sdo_d    = 1'b0;
      if (rx_done) begin
         status_d = rx_status;
         if (rx_status == ST_OK) begin
            for (int b = 0; b < NBANK; b++) begin
               if (int'(rx_addr) == b) begin
                  cnf_d[b*DATAW +: DATAW] = rx_data;
                  upd_d[b]                = 1'b1;
               end
            end
         end
      end
      if (rx_addr_last) begin
         rb_d  = rb_new;
         sdo_d = rb_new[DATAW-1];
      end else if (rx_data_bit) begin
         rb_d = rb_q << 1;
         if (!rx_data_last) sdo_d = rb_q[DATAW-2];
      end
   end

   assign SDO    = sdo_q;
   assign CNF    = cnf_q;
   assign UPD    = upd_q;
   assign STATUS = status_q;
   assign BUSY   = rx_busy;

endmodule
